// File: rtl/wimax_pkg.sv
// Shared types, geometry constants and mode lookups for the multimode
// 802.16 OFDM bit interleaver.
package wimax_pkg;

  localparam int N_DATA_SC = 96;
  localparam int D         = 16;
  localparam int MAX_NCPC  = 6;
  localparam int MAX_NCBPS = N_DATA_SC * MAX_NCPC;

  // Widths: bit index within a block, row (k mod D), column (k / D).
  localparam int AW = $clog2(MAX_NCBPS);
  localparam int RW = $clog2(D);
  localparam int CW = $clog2(MAX_NCBPS / D);

  typedef enum logic [1:0] {
    QPSK  = 2'b00,
    QAM16 = 2'b01,
    QAM64 = 2'b10
  } mod_mode_t;

  typedef enum logic {W_IDLE, W_FILL}  wr_state_t;
  typedef enum logic {R_EMPTY, R_DRAIN} rd_state_t;

  // The reserved code 11 falls back to QPSK.
  function automatic mod_mode_t decode_mode(input logic [1:0] m);
    mod_mode_t mm;
    case (m)
      2'b01:   mm = QAM16;
      2'b10:   mm = QAM64;
      default: mm = QPSK;
    endcase
    return mm;
  endfunction

  // s = Ncpc / 2
  function automatic logic [1:0] s_of(input mod_mode_t m);
    logic [1:0] s;
    case (m)
      QAM16:   s = 2'd2;
      QAM64:   s = 2'd3;
      default: s = 2'd1;
    endcase
    return s;
  endfunction

  // Ncbps = N_DATA_SC * Ncpc = N_DATA_SC * 2 * s
  function automatic logic [AW-1:0] ncbps_of(input mod_mode_t m);
    return AW'(N_DATA_SC * 2 * int'(s_of(m)));
  endfunction

  // Number of columns, Ncbps / D
  function automatic logic [AW-1:0] cols_of(input mod_mode_t m);
    return AW'((N_DATA_SC * 2 * int'(s_of(m))) / D);
  endfunction

endpackage

// File: rtl/interleaver_addr_gen.sv
// Combinational write-address generator: maps input index k (given as
// row r = k mod D and column c = k / D) to its permuted position jk.
// The mod-3 terms for 64-QAM come from small running counters, so no
// divider is needed on the full-width index.
module interleaver_addr_gen
  import wimax_pkg::*;
(
  input  logic [1:0]    mode,
  input  logic [RW-1:0] r,
  input  logic [CW-1:0] c,
  input  logic [1:0]    r_mod3,
  input  logic [1:0]    c_mod3,
  output logic [AW-1:0] jk
);

  mod_mode_t     mode_e;
  logic [AW-1:0] mk;
  logic [2:0]    diff3;

  assign mode_e = mod_mode_t'(mode);

  // First permutation, then the per-symbol rotation inside groups of s bits.
  // For s = 3 the column count (36) is a multiple of 3, so mk mod 3 equals
  // c mod 3 and (mk - r) mod 3 equals (c - r) mod 3.
  always_comb begin
    mk    = cols_of(mode_e) * AW'(r) + AW'(c);
    diff3 = (c_mod3 >= r_mod3) ? (3'(c_mod3) - 3'(r_mod3))
                               : (3'(c_mod3) + 3'd3 - 3'(r_mod3));
    jk    = mk;
    case (s_of(mode_e))
      2'd2:    jk = {mk[AW-1:1], mk[0] ^ r[0]};
      2'd3:    jk = mk - AW'(c_mod3) + AW'(diff3);
      default: jk = mk;
    endcase
  end

endmodule

// File: rtl/interleaver_multimode.sv
// Ping-pong buffered multimode OFDM bit interleaver. One bank fills with
// permuted write addresses while the other drains sequentially toward the
// mapper. Each bank remembers the mode it was filled with, so consecutive
// blocks may use different constellations.
module interleaver_multimode
  import wimax_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mod_mode,
  input  logic       valid_fec,
  input  logic       data_in,
  output logic       ready_interleaver,
  output logic       valid_interleaver,
  output logic       data_out,
  input  logic       ready_mod,
  output logic       first_out,
  output logic       last_out,
  output logic [1:0] mode_out
);

  wr_state_t     wr_state_reg, wr_state_next;
  logic          wr_bank_reg, wr_bank_next;
  mod_mode_t     wr_mode_reg, wr_mode_next;
  logic [AW-1:0] wr_cnt_reg, wr_cnt_next;
  logic [RW-1:0] r_reg, r_next;
  logic [CW-1:0] c_reg, c_next;
  logic [1:0]    rm3_reg, rm3_next;
  logic [1:0]    cm3_reg, cm3_next;

  rd_state_t     rd_state_reg, rd_state_next;
  logic          rd_bank_reg, rd_bank_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;

  logic [1:0]    full_reg, full_next;
  mod_mode_t     bank_mode_reg [2];

  mod_mode_t     eff_mode, rd_mode;
  logic          accept, emit, wr_last, rd_last;
  logic [AW-1:0] jk;
  logic [1:0]    rd_bit;

  // The mode is taken live from mod_mode for k = 0 and held afterwards.
  assign eff_mode          = (wr_state_reg == W_IDLE) ? decode_mode(mod_mode) : wr_mode_reg;
  assign ready_interleaver = ~full_reg[wr_bank_reg];
  assign accept            = valid_fec & ready_interleaver;
  assign wr_last           = (wr_cnt_reg == ncbps_of(eff_mode) - AW'(1));

  assign rd_mode           = bank_mode_reg[rd_bank_reg];
  assign valid_interleaver = (rd_state_reg == R_DRAIN);
  assign emit              = valid_interleaver & ready_mod;
  assign rd_last           = (rd_ptr_reg == ncbps_of(rd_mode) - AW'(1));

  assign data_out  = valid_interleaver & rd_bit[rd_bank_reg];
  assign first_out = valid_interleaver & (rd_ptr_reg == '0);
  assign last_out  = valid_interleaver & rd_last;
  assign mode_out  = valid_interleaver ? rd_mode : 2'b00;

  interleaver_addr_gen u_addr_gen (
    .mode   (eff_mode),
    .r      (r_reg),
    .c      (c_reg),
    .r_mod3 (rm3_reg),
    .c_mod3 (cm3_reg),
    .jk     (jk)
  );

  // Two 1-bit-wide banks; data is never reset, only the full flags are.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [MAX_NCBPS-1:0] mem_reg;

      // Store the accepted bit at its permuted address in this bank.
      always_ff @(posedge clk) begin
        if (accept && (wr_bank_reg == 1'(gi))) begin
          mem_reg[jk] <= data_in;
        end
      end

      assign rd_bit[gi] = mem_reg[rd_ptr_reg];
    end
  endgenerate

  // Write FSM: step row/column counters (and their mod-3 shadows) per accept.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_bank_next  = wr_bank_reg;
    wr_mode_next  = wr_mode_reg;
    wr_cnt_next   = wr_cnt_reg;
    r_next        = r_reg;
    c_next        = c_reg;
    rm3_next      = rm3_reg;
    cm3_next      = cm3_reg;
    if (accept) begin
      if (wr_last) begin
        wr_state_next = W_IDLE;
        wr_bank_next  = ~wr_bank_reg;
        wr_cnt_next   = '0;
        r_next        = '0;
        c_next        = '0;
        rm3_next      = '0;
        cm3_next      = '0;
      end else begin
        wr_state_next = W_FILL;
        wr_mode_next  = eff_mode;
        wr_cnt_next   = wr_cnt_reg + AW'(1);
        if (r_reg == RW'(D - 1)) begin
          r_next   = '0;
          rm3_next = '0;
          c_next   = c_reg + CW'(1);
          cm3_next = (cm3_reg == 2'd2) ? 2'd0 : cm3_reg + 2'd1;
        end else begin
          r_next   = r_reg + RW'(1);
          rm3_next = (rm3_reg == 2'd2) ? 2'd0 : rm3_reg + 2'd1;
        end
      end
    end
  end

  // Read FSM and bank ownership: a completed write sets a flag, the final
  // emit of a bank clears it; both may happen in the same cycle.
  always_comb begin
    full_next    = full_reg;
    rd_bank_next = rd_bank_reg;
    rd_ptr_next  = rd_ptr_reg;
    if (accept && wr_last) begin
      full_next[wr_bank_reg] = 1'b1;
    end
    if (emit) begin
      if (rd_last) begin
        full_next[rd_bank_reg] = 1'b0;
        rd_bank_next           = ~rd_bank_reg;
        rd_ptr_next            = '0;
      end else begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
    end
    rd_state_next = full_next[rd_bank_next] ? R_DRAIN : R_EMPTY;
  end

  // Write-side state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_reg <= W_IDLE;
      wr_bank_reg  <= 1'b0;
      wr_mode_reg  <= QPSK;
      wr_cnt_reg   <= '0;
      r_reg        <= '0;
      c_reg        <= '0;
      rm3_reg      <= '0;
      cm3_reg      <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_bank_reg  <= wr_bank_next;
      wr_mode_reg  <= wr_mode_next;
      wr_cnt_reg   <= wr_cnt_next;
      r_reg        <= r_next;
      c_reg        <= c_next;
      rm3_reg      <= rm3_next;
      cm3_reg      <= cm3_next;
    end
  end

  // Read-side state register, full flags and the per-bank mode tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_reg     <= R_EMPTY;
      rd_bank_reg      <= 1'b0;
      rd_ptr_reg       <= '0;
      full_reg         <= '0;
      bank_mode_reg[0] <= QPSK;
      bank_mode_reg[1] <= QPSK;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_bank_reg  <= rd_bank_next;
      rd_ptr_reg   <= rd_ptr_next;
      full_reg     <= full_next;
      if (accept && wr_last) begin
        bank_mode_reg[wr_bank_reg] <= eff_mode;
      end
    end
  end

endmodule
